// File: rtl/uart_rx_param.sv
// Oversampled UART receiver with configurable frame format and a one-word
// hold register offering valid/ready handshake, error flags and sticky overrun.
module uart_rx_param #(
  parameter int NB_DATA    = 8,
  parameter int OVERSAMPLE = 16,
  parameter int NB_STOP    = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_parity_err,
  output logic               o_frame_err,
  output logic               o_overrun,
  output logic               o_busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(NB_DATA + 1);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t             state, state_n;
  logic               rx_m, rxs;
  logic [TW-1:0]      cnt, cnt_n;
  logic [BW-1:0]      bitc, bitc_n;
  logic [NB_DATA-1:0] sh, sh_n;
  logic               perr, perr_n, ferr, ferr_n;
  logic               done, done_n;
  logic               samp, xfer;

  assign samp   = i_tick && (cnt == LAST);
  assign xfer   = o_valid && i_ready;
  assign o_busy = (state != IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bitc_n  = bitc;
    sh_n    = sh;
    perr_n  = perr;
    ferr_n  = ferr;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rxs) begin
          state_n = START;
          bitc_n  = '0;
          perr_n  = 1'b0;
          ferr_n  = 1'b0;
        end
      end
      START: if (i_tick) begin
        if (cnt == HALF) begin
          // Mid-start sample: a high line here was just a glitch
          if (rxs) state_n = IDLE;
          else begin
            state_n = DATA;
            cnt_n   = '0;
            bitc_n  = '0;
          end
        end else cnt_n = cnt + TW'(1);
      end
      DATA: if (i_tick) begin
        if (samp) begin
          cnt_n = '0;
          sh_n  = {rxs, sh[NB_DATA-1:1]};
          if (bitc == BW'(NB_DATA - 1)) begin
            bitc_n  = '0;
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
          end else bitc_n = bitc + BW'(1);
        end else cnt_n = cnt + TW'(1);
      end
      PARITY: if (i_tick) begin
        if (samp) begin
          cnt_n   = '0;
          perr_n  = ^sh ^ rxs ^ 1'(PARITY_ODD);
          state_n = STOP;
        end else cnt_n = cnt + TW'(1);
      end
      STOP: if (i_tick) begin
        if (samp) begin
          cnt_n = '0;
          if (!rxs) ferr_n = 1'b1;
          // Leave at the last stop sample so a back-to-back start edge is not missed
          if (bitc == BW'(NB_STOP - 1)) begin
            bitc_n  = '0;
            state_n = IDLE;
            done_n  = 1'b1;
          end else bitc_n = bitc + BW'(1);
        end else cnt_n = cnt + TW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      rx_m  <= 1'b1;
      rxs   <= 1'b1;
      state <= IDLE;
      cnt   <= '0;
      bitc  <= '0;
      sh    <= '0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      done  <= 1'b0;
    end else begin
      rx_m  <= i_rx;
      rxs   <= rx_m;
      state <= state_n;
      cnt   <= cnt_n;
      bitc  <= bitc_n;
      sh    <= sh_n;
      perr  <= perr_n;
      ferr  <= ferr_n;
      done  <= done_n;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      if (done && (!o_valid || i_ready)) begin
        o_data       <= sh;
        o_parity_err <= perr;
        o_frame_err  <= ferr;
        o_valid      <= 1'b1;
      end else if (xfer) begin
        o_valid <= 1'b0;
      end
      // A word lost in the same cycle as a transfer keeps the flag set
      if (done && o_valid && !i_ready) o_overrun <= 1'b1;
      else if (xfer)                   o_overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three parameterisations share clk/tick,
// expected words are queued per instance and checked by a handshake monitor.
module tb_uart_rx_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick;
  logic [2:0] rx = 3'b111;
  logic [2:0] rdy = 3'b111;
  logic [2:0] vld, pe, fe, ovr, busy;
  logic [2:0][7:0] dat;
  int tp = 1;
  int tcnt = 0;
  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  always @(posedge clk) tcnt <= (tcnt >= tp - 1) ? 0 : tcnt + 1;
  assign tick = (tcnt == 0);

  uart_rx_param u_d (
    .clk(clk), .i_rst(rst), .i_tick(tick), .i_rx(rx[0]), .o_data(dat[0]),
    .o_valid(vld[0]), .i_ready(rdy[0]), .o_parity_err(pe[0]),
    .o_frame_err(fe[0]), .o_overrun(ovr[0]), .o_busy(busy[0]));

  uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0)) u_p (
    .clk(clk), .i_rst(rst), .i_tick(tick), .i_rx(rx[1]), .o_data(dat[1]),
    .o_valid(vld[1]), .i_ready(rdy[1]), .o_parity_err(pe[1]),
    .o_frame_err(fe[1]), .o_overrun(ovr[1]), .o_busy(busy[1]));

  uart_rx_param #(.NB_STOP(2)) u_s (
    .clk(clk), .i_rst(rst), .i_tick(tick), .i_rx(rx[2]), .o_data(dat[2]),
    .o_valid(vld[2]), .i_ready(rdy[2]), .o_parity_err(pe[2]),
    .o_frame_err(fe[2]), .o_overrun(ovr[2]), .o_busy(busy[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int s, input logic [7:0] d, input logic p, input logic f);
    exp_t e;
    e = '{d: d, pe: p, fe: f};
    case (s)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int s);
    case (s)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic pop_chk(input int s);
    exp_t e;
    logic ok;
    ok = 1'b0;
    e  = '0;
    if (qsize(s) > 0) begin
      ok = 1'b1;
      case (s)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
    end
    check($sformatf("expected_word_u%0d", s), 32'(ok), 32'd1);
    if (ok) begin
      check($sformatf("data_u%0d", s), 32'(dat[s]), 32'(e.d));
      check($sformatf("parity_err_u%0d", s), 32'(pe[s]), 32'(e.pe));
      check($sformatf("frame_err_u%0d", s), 32'(fe[s]), 32'(e.fe));
    end
  endtask

  // Every accepted transfer must match the head of that instance's queue
  always @(negedge clk) begin
    if (!rst) begin
      for (int s = 0; s < 3; s++)
        if (vld[s] && rdy[s]) pop_chk(s);
    end
  end

  task automatic send_bit(input int s, input logic b);
    rx[s] = b;
    wait_clk(16 * tp);
  endtask

  // pmode < 0: no parity bit; otherwise pmode[0] is the parity bit sent
  task automatic send_frame(input int s, input logic [7:0] d, input int pmode,
                            input logic st1, input logic st2, input int nstop);
    send_bit(s, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(s, d[i]);
    if (pmode >= 0) send_bit(s, pmode[0]);
    send_bit(s, st1);
    if (nstop == 2) send_bit(s, st2);
    rx[s] = 1'b1;
    wait_clk(20);
  endtask

  task automatic drain(input int s);
    int n;
    n = 0;
    while (qsize(s) != 0 && n < 400) begin
      wait_clk(1);
      n++;
    end
    check($sformatf("drain_u%0d", s), 32'(qsize(s)), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic pb;

    // Reset state
    wait_clk(3);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst_valid_u%0d", s), 32'(vld[s]), 32'd0);
      check($sformatf("rst_busy_u%0d", s), 32'(busy[s]), 32'd0);
      check($sformatf("rst_data_u%0d", s), 32'(dat[s]), 32'd0);
      check($sformatf("rst_flags_u%0d", s), {29'd0, pe[s], fe[s], ovr[s]}, 32'd0);
    end
    rst = 1'b0;
    wait_clk(5);

    // 8N1 frames, tick every clk, including all-zero / all-one payloads
    push(0, 8'hA5, 1'b0, 1'b0);
    send_frame(0, 8'hA5, -1, 1'b1, 1'b1, 1);
    drain(0);
    check("a5_valid_one_clk", 32'(vld[0]), 32'd0);
    check("a5_overrun", 32'(ovr[0]), 32'd0);
    push(0, 8'h00, 1'b0, 1'b0);
    send_frame(0, 8'h00, -1, 1'b1, 1'b1, 1);
    push(0, 8'hFF, 1'b0, 1'b0);
    send_frame(0, 8'hFF, -1, 1'b1, 1'b1, 1);
    drain(0);

    // Ticks every other clk: counter must only advance on the strobe
    tp = 2;
    wait_clk(4);
    push(0, 8'hC3, 1'b0, 1'b0);
    send_frame(0, 8'hC3, -1, 1'b1, 1'b1, 1);
    drain(0);
    tp = 1;
    wait_clk(4);

    // False start: 4 ticks low then idle
    rx[0] = 1'b0;
    wait_clk(3);
    check("false_start_busy", 32'(busy[0]), 32'd1);
    wait_clk(1);
    rx[0] = 1'b1;
    wait_clk(30);
    check("false_start_idle", 32'(busy[0]), 32'd0);
    check("false_start_no_valid", 32'(vld[0]), 32'd0);

    // Even parity on 0x07 (three ones): parity bit 0 is wrong, 1 is right
    d = 8'h07;
    pb = 1'b0;
    push(1, d, ^d ^ pb, 1'b0);
    send_frame(1, d, 0, 1'b1, 1'b1, 1);
    pb = 1'b1;
    push(1, d, ^d ^ pb, 1'b0);
    send_frame(1, d, 1, 1'b1, 1'b1, 1);
    d = 8'h96;
    pb = 1'b0;
    push(1, d, ^d ^ pb, 1'b0);
    send_frame(1, d, 0, 1'b1, 1'b1, 1);
    drain(1);

    // Two stop bits: low second stop is a frame error, next frame clean
    push(2, 8'h81, 1'b0, 1'b1);
    send_frame(2, 8'h81, -1, 1'b1, 1'b0, 2);
    wait_clk(30);
    push(2, 8'h3C, 1'b0, 1'b0);
    send_frame(2, 8'h3C, -1, 1'b1, 1'b1, 2);
    drain(2);

    // Overrun: consumer stalled across two frames
    rdy[0] = 1'b0;
    push(0, 8'h11, 1'b0, 1'b0);
    send_frame(0, 8'h11, -1, 1'b1, 1'b1, 1);
    send_frame(0, 8'h22, -1, 1'b1, 1'b1, 1);
    check("ovr_valid_held", 32'(vld[0]), 32'd1);
    check("ovr_data_held", 32'(dat[0]), 32'h11);
    check("ovr_flag", 32'(ovr[0]), 32'd1);
    rdy[0] = 1'b1;
    wait_clk(1);
    rdy[0] = 1'b0;
    check("ovr_after_xfer_valid", 32'(vld[0]), 32'd0);
    check("ovr_after_xfer_flag", 32'(ovr[0]), 32'd0);
    check("ovr_queue_empty", 32'(qsize(0)), 32'd0);
    rdy[0] = 1'b1;

    // Reset pulse mid-DATA aborts the frame
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    check("mid_frame_busy", 32'(busy[0]), 32'd1);
    rx[0] = 1'b1;
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy[0]), 32'd0);
    check("mid_rst_valid", 32'(vld[0]), 32'd0);
    check("mid_rst_data", 32'(dat[0]), 32'd0);
    check("mid_rst_flags", {29'd0, pe[0], fe[0], ovr[0]}, 32'd0);
    wait_clk(200);
    check("mid_rst_no_valid", 32'(vld[0]), 32'd0);
    push(0, 8'h5A, 1'b0, 1'b0);
    send_frame(0, 8'h5A, -1, 1'b1, 1'b1, 1);
    drain(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
